// File: rtl/pt2272_decoder_gen.sv
// PT2272-compatible trinary word receiver: tick-oversampled pulse-width symbol
// recovery, address match against pin config, two-word confirmation to D/dv/vt.
//
// state       | meaning
// HUNT        | waiting for a sync; all other symbols ignored
// HALF0       | expecting first half-symbol of a trit
// HALF1       | expecting second half-symbol; trit stored at idx
// EXPECT_SYNC | full word received, trailing sync evaluates it
module pt2272_decoder_gen #(
    parameter int N_ADDR     = 8,
    parameter int N_DATA     = 4,
    parameter int CLK_DIV    = 250,
    parameter int SHORT_MIN  = 2,
    parameter int SHORT_MAX  = 6,
    parameter int LONG_MIN   = 9,
    parameter int LONG_MAX   = 15,
    parameter int SYNC_MIN   = 100,
    parameter int VT_TIMEOUT = 512,
    parameter int LATCHED    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_ADDR-1:0] addr_val,
    input  logic [N_ADDR-1:0] addr_float,
    input  logic              cod_i,
    output logic [N_DATA-1:0] D,
    output logic              dv,
    output logic              vt,
    output logic              err
);

    localparam int N_TRIT = N_ADDR + N_DATA;
    localparam int W_MAX  = (SYNC_MIN > LONG_MAX) ? SYNC_MIN : LONG_MAX;
    localparam int WW     = $clog2(W_MAX + 2);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW     = (N_TRIT > 1) ? $clog2(N_TRIT) : 1;
    localparam int TW     = $clog2(VT_TIMEOUT + 1);

    localparam logic [1:0] TRIT_0 = 2'd0;
    localparam logic [1:0] TRIT_1 = 2'd1;
    localparam logic [1:0] TRIT_F = 2'd2;

    typedef enum logic [1:0] {HUNT, HALF0, HALF1, EXPECT_SYNC} state_t;
    typedef enum logic [2:0] {SYM_NONE, SYM_S0, SYM_S1, SYM_BAD, SYM_SYNC} sym_t;

    logic          cod_s1_q, cod_s2_q, level_q, sync_low_q;
    logic [DW-1:0] div_q;
    logic [WW-1:0] wid_q, hw_q, wid_inc;
    logic          tick, lvl_chg, rise, sync_hit;
    sym_t          sym;

    function automatic logic is_short(input logic [WW-1:0] w);
        return (w >= WW'(SHORT_MIN)) && (w <= WW'(SHORT_MAX));
    endfunction

    function automatic logic is_long(input logic [WW-1:0] w);
        return (w >= WW'(LONG_MIN)) && (w <= WW'(LONG_MAX));
    endfunction

    assign tick     = (div_q == DW'(CLK_DIV - 1));
    assign lvl_chg  = (cod_s2_q != level_q);
    assign rise     = lvl_chg && cod_s2_q;
    assign wid_inc  = (wid_q == '1) ? wid_q : wid_q + WW'(1);
    assign sync_hit = tick && !lvl_chg && !level_q && !sync_low_q &&
                      (wid_inc == WW'(SYNC_MIN)) && is_short(hw_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cod_s1_q   <= 1'b0;
            cod_s2_q   <= 1'b0;
            div_q      <= '0;
            level_q    <= 1'b0;
            wid_q      <= '0;
            hw_q       <= '0;
            sync_low_q <= 1'b0;
        end else begin
            cod_s1_q <= cod_i;
            cod_s2_q <= cod_s1_q;
            div_q    <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
                if (lvl_chg) begin
                    level_q <= cod_s2_q;
                    wid_q   <= WW'(1);
                    if (!cod_s2_q) hw_q <= wid_q;
                    else           sync_low_q <= 1'b0;
                end else begin
                    wid_q <= wid_inc;
                    if (sync_hit) sync_low_q <= 1'b1;
                end
            end
        end
    end

    // The rising edge closing a sync low carries no symbol.
    always_comb begin
        sym = SYM_NONE;
        if (sync_hit) begin
            sym = SYM_SYNC;
        end else if (tick && rise && !sync_low_q) begin
            if (is_short(hw_q) && is_long(wid_q))      sym = SYM_S0;
            else if (is_long(hw_q) && is_short(wid_q)) sym = SYM_S1;
            else                                       sym = SYM_BAD;
        end
    end

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   half_q, half_d;
    logic [N_TRIT-1:0][1:0] trits_q, trits_d;
    logic [N_DATA-1:0]      cand_q, cand_d, d_q, d_d, data_w;
    logic                   cand_vld_q, cand_vld_d, vt_q, vt_d;
    logic                   dv_q, dv_d, err_q, err_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   eval, addr_ok, data_has_f;
    logic [1:0]             trit_new;

    always_comb begin
        addr_ok    = 1'b1;
        data_has_f = 1'b0;
        data_w     = '0;
        for (int i = 0; i < N_ADDR; i++) begin
            if (addr_float[i]) begin
                if (trits_q[i] != TRIT_F) addr_ok = 1'b0;
            end else if (trits_q[i] != {1'b0, addr_val[i]}) begin
                addr_ok = 1'b0;
            end
        end
        for (int j = 0; j < N_DATA; j++) begin
            data_w[j] = (trits_q[N_ADDR+j] == TRIT_1);
            if (trits_q[N_ADDR+j] == TRIT_F) data_has_f = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        half_d     = half_q;
        trits_d    = trits_q;
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        d_d        = d_q;
        vt_d       = vt_q;
        tmo_d      = tmo_q;
        dv_d       = 1'b0;
        err_d      = 1'b0;
        eval       = 1'b0;
        trit_new   = TRIT_0;

        if (tick && vt_q) begin
            if (tmo_q <= TW'(1)) begin
                tmo_d      = '0;
                vt_d       = 1'b0;
                cand_vld_d = 1'b0;
                if (LATCHED == 0) d_d = '0;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end

        case (state_q)
            HUNT: begin
                if (sym == SYM_SYNC) begin
                    state_d = HALF0;
                    idx_d   = '0;
                end
            end
            HALF0: begin
                case (sym)
                    SYM_S0, SYM_S1: begin
                        half_d  = (sym == SYM_S1);
                        state_d = HALF1;
                    end
                    SYM_SYNC: begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end
                    SYM_BAD: begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                    default: ;
                endcase
            end
            HALF1: begin
                case (sym)
                    SYM_S0, SYM_S1: begin
                        if (half_q && sym == SYM_S0) begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end else begin
                            if (half_q)              trit_new = TRIT_1;
                            else if (sym == SYM_S0)  trit_new = TRIT_0;
                            else                     trit_new = TRIT_F;
                            trits_d[idx_q] = trit_new;
                            if (idx_q == IW'(N_TRIT - 1)) begin
                                state_d = EXPECT_SYNC;
                            end else begin
                                idx_d   = idx_q + IW'(1);
                                state_d = HALF0;
                            end
                        end
                    end
                    SYM_SYNC: begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = HALF0;
                    end
                    SYM_BAD: begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                    default: ;
                endcase
            end
            EXPECT_SYNC: begin
                case (sym)
                    SYM_SYNC: begin
                        eval    = 1'b1;
                        idx_d   = '0;
                        state_d = HALF0;
                    end
                    SYM_S0, SYM_S1, SYM_BAD: begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                    default: ;
                endcase
            end
            default: state_d = HUNT;
        endcase

        // Evaluated after the timeout so a same-tick confirmation overrides it.
        if (eval) begin
            if (data_has_f) begin
                err_d      = 1'b1;
                cand_vld_d = 1'b0;
            end else if (addr_ok) begin
                tmo_d = TW'(VT_TIMEOUT);
                if (cand_vld_q && cand_q == data_w) begin
                    d_d        = data_w;
                    vt_d       = 1'b1;
                    cand_vld_d = 1'b1;
                    dv_d       = !vt_q || (d_q != data_w);
                end else begin
                    cand_d     = data_w;
                    cand_vld_d = 1'b1;
                end
            end else begin
                cand_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            idx_q      <= '0;
            half_q     <= 1'b0;
            trits_q    <= '0;
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            d_q        <= '0;
            vt_q       <= 1'b0;
            tmo_q      <= '0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            half_q     <= half_d;
            trits_q    <= trits_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            d_q        <= d_d;
            vt_q       <= vt_d;
            tmo_q      <= tmo_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
        end
    end

    assign D   = d_q;
    assign dv  = dv_q;
    assign vt  = vt_q;
    assign err = err_q;

endmodule

// File: tb/tb_pt2272_decoder_gen.sv
// Bench for pt2272_decoder_gen: latched and momentary instances share one
// serial stream; expected dv words are queued and popped as dv pulses appear.
module tb_pt2272_decoder_gen;

    localparam int CLK_DIV = 4;
    localparam int VT_TO   = 1500;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cod;
    logic [7:0] addr_val, addr_float;
    logic [3:0] d_l, d_m;
    logic       dv_l, dv_m, vt_l, vt_m, err_l, err_m;

    int n_vec = 0;
    int n_bad = 0;
    int dv_cnt_l = 0, dv_cnt_m = 0, err_cnt_l = 0, err_cnt_m = 0;
    logic [3:0] exp_l[$];
    logic [3:0] exp_m[$];

    always #5 clk = ~clk;

    pt2272_decoder_gen #(.CLK_DIV(CLK_DIV), .VT_TIMEOUT(VT_TO), .LATCHED(1)) dut_l (
        .clk(clk), .reset(rst_n), .addr_val(addr_val), .addr_float(addr_float),
        .cod_i(cod), .D(d_l), .dv(dv_l), .vt(vt_l), .err(err_l)
    );

    pt2272_decoder_gen #(.CLK_DIV(CLK_DIV), .VT_TIMEOUT(VT_TO), .LATCHED(0)) dut_m (
        .clk(clk), .reset(rst_n), .addr_val(addr_val), .addr_float(addr_float),
        .cod_i(cod), .D(d_m), .dv(dv_m), .vt(vt_m), .err(err_m)
    );

    // Drives a level for n ticks; every dv pulse seen is matched against the queue.
    task automatic hold(input logic v, input int n);
        logic [3:0] e;
        cod = v;
        repeat (n * CLK_DIV) begin
            @(negedge clk);
            if (dv_l) begin
                dv_cnt_l++;
                n_vec++;
                if (exp_l.size() == 0) begin
                    n_bad++;
                    $display("FAIL dv_l_unexpected got D=%h required no dv", d_l);
                end else begin
                    e = exp_l.pop_front();
                    if (d_l !== e) begin
                        n_bad++;
                        $display("FAIL dv_l_data got %h required %h", d_l, e);
                    end
                end
            end
            if (dv_m) begin
                dv_cnt_m++;
                n_vec++;
                if (exp_m.size() == 0) begin
                    n_bad++;
                    $display("FAIL dv_m_unexpected got D=%h required no dv", d_m);
                end else begin
                    e = exp_m.pop_front();
                    if (d_m !== e) begin
                        n_bad++;
                        $display("FAIL dv_m_data got %h required %h", d_m, e);
                    end
                end
            end
            if (err_l) err_cnt_l++;
            if (err_m) err_cnt_m++;
        end
    endtask

    task automatic send_sym(input bit s1, input int sh, input int lg);
        if (s1) begin
            hold(1'b1, lg);
            hold(1'b0, sh);
        end else begin
            hold(1'b1, sh);
            hold(1'b0, lg);
        end
    endtask

    task automatic send_sync();
        hold(1'b1, 4);
        hold(1'b0, 124);
    endtask

    // f_hi/f_lo override the very first half-symbol; bad2 sends pin 2 as 0.
    task automatic send_word(input logic [3:0] data, input int sh, input int lg,
                             input int f_hi, input int f_lo, input bit bad2, input int n_tr);
        logic [1:0] t;
        bit         s1;
        for (int i = 0; i < n_tr; i++) begin
            if (i < 8) begin
                if (addr_float[i]) t = (bad2 && i == 2) ? 2'd0 : 2'd2;
                else               t = {1'b0, addr_val[i]};
            end else begin
                t = {1'b0, data[i-8]};
            end
            for (int h = 0; h < 2; h++) begin
                s1 = (t == 2'd1) || (t == 2'd2 && h == 1);
                if (i == 0 && h == 0 && f_hi != 0) begin
                    hold(1'b1, f_hi);
                    hold(1'b0, f_lo);
                end else begin
                    send_sym(s1, sh, lg);
                end
            end
        end
        if (n_tr == 12) send_sync();
    endtask

    task automatic word(input logic [3:0] data);
        send_word(data, 4, 12, 0, 0, 1'b0, 12);
    endtask

    task automatic push(input logic [3:0] data);
        exp_l.push_back(data);
        exp_m.push_back(data);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({d_l, dv_l, vt_l, err_l, d_m, dv_m, vt_m, err_m} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h required 0", {d_l, dv_l, vt_l, err_l, d_m, dv_m, vt_m, err_m});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_confirm();
        int dv0 = dv_cnt_l;
        word(4'hA);
        n_vec++;
        if (dv_cnt_l != dv0 || vt_l !== 1'b0 || d_l !== 4'h0) begin
            n_bad++;
            $display("FAIL confirm_first dv=%0d vt=%b D=%h required dv=0 vt=0 D=0", dv_cnt_l - dv0, vt_l, d_l);
        end
        push(4'hA);
        word(4'hA);
        n_vec++;
        if (exp_l.size() != 0 || exp_m.size() != 0 || dv_cnt_l != dv0 + 1 || dv_cnt_m != dv0 + 1) begin
            n_bad++;
            $display("FAIL confirm_dv got %0d pulses, %0d pending required 1 pulse", dv_cnt_l - dv0, exp_l.size());
        end
        n_vec++;
        if ({d_l, vt_l, d_m, vt_m} !== {4'hA, 1'b1, 4'hA, 1'b1}) begin
            n_bad++;
            $display("FAIL confirm_out got %h required %h", {d_l, vt_l, d_m, vt_m}, {4'hA, 1'b1, 4'hA, 1'b1});
        end
        n_vec++;
        if (err_cnt_l != 0 || err_cnt_m != 0) begin
            n_bad++;
            $display("FAIL confirm_err got %0d/%0d required 0", err_cnt_l, err_cnt_m);
        end
    endtask

    task automatic test_repeat();
        int dv0 = dv_cnt_l;
        word(4'hA);
        word(4'hA);
        n_vec++;
        if (dv_cnt_l != dv0 || {d_l, vt_l, d_m, vt_m} !== {4'hA, 1'b1, 4'hA, 1'b1}) begin
            n_bad++;
            $display("FAIL repeat got dv=%0d out=%h required dv=0 out=%h", dv_cnt_l - dv0, {d_l, vt_l, d_m, vt_m}, {4'hA, 1'b1, 4'hA, 1'b1});
        end
    endtask

    task automatic test_change();
        int dv0 = dv_cnt_l;
        word(4'hA);
        word(4'h5);
        n_vec++;
        if (dv_cnt_l != dv0 || d_l !== 4'hA) begin
            n_bad++;
            $display("FAIL change_early got dv=%0d D=%h required dv=0 D=a", dv_cnt_l - dv0, d_l);
        end
        push(4'h5);
        word(4'h5);
        n_vec++;
        if (dv_cnt_l != dv0 + 1 || exp_l.size() != 0 || {d_l, d_m} !== 8'h55) begin
            n_bad++;
            $display("FAIL change_update got dv=%0d D=%h/%h required dv=1 D=5/5", dv_cnt_l - dv0, d_l, d_m);
        end
    endtask

    task automatic test_addr_mismatch();
        int dv0 = dv_cnt_l;
        int e0  = err_cnt_l;
        word(4'hA);
        send_word(4'hA, 4, 12, 0, 0, 1'b1, 12);
        n_vec++;
        if (dv_cnt_l != dv0 || d_l !== 4'h5) begin
            n_bad++;
            $display("FAIL mismatch_word got dv=%0d D=%h required dv=0 D=5", dv_cnt_l - dv0, d_l);
        end
        word(4'hA);
        n_vec++;
        if (dv_cnt_l != dv0 || d_l !== 4'h5) begin
            n_bad++;
            $display("FAIL mismatch_cand_cleared got dv=%0d D=%h required dv=0 D=5", dv_cnt_l - dv0, d_l);
        end
        push(4'hA);
        word(4'hA);
        n_vec++;
        if (dv_cnt_l != dv0 + 1 || exp_l.size() != 0 || {d_l, vt_l} !== {4'hA, 1'b1} || err_cnt_l != e0) begin
            n_bad++;
            $display("FAIL mismatch_recover got dv=%0d D=%h vt=%b err=%0d required dv=1 D=a vt=1 err=0", dv_cnt_l - dv0, d_l, vt_l, err_cnt_l - e0);
        end
    endtask

    task automatic test_tolerance();
        int dv0 = dv_cnt_l;
        int e0  = err_cnt_l;
        send_word(4'h5, 2, 9, 0, 0, 1'b0, 12);
        n_vec++;
        if (dv_cnt_l != dv0 || err_cnt_l != e0) begin
            n_bad++;
            $display("FAIL tol_min got dv=%0d err=%0d required 0/0", dv_cnt_l - dv0, err_cnt_l - e0);
        end
        push(4'h5);
        send_word(4'h5, 6, 15, 0, 0, 1'b0, 12);
        n_vec++;
        if (dv_cnt_l != dv0 + 1 || exp_l.size() != 0 || d_l !== 4'h5 || err_cnt_l != e0) begin
            n_bad++;
            $display("FAIL tol_max got dv=%0d D=%h err=%0d required dv=1 D=5 err=0", dv_cnt_l - dv0, d_l, err_cnt_l - e0);
        end
    endtask

    task automatic test_bad_width(input int f_hi, input int f_lo, input logic [3:0] data, input logic [3:0] prev);
        int dv0 = dv_cnt_l;
        int e0  = err_cnt_l;
        int m0  = err_cnt_m;
        send_word(data, 4, 12, f_hi, f_lo, 1'b0, 12);
        n_vec++;
        if (err_cnt_l != e0 + 1 || err_cnt_m != m0 + 1 || dv_cnt_l != dv0) begin
            n_bad++;
            $display("FAIL bad_width_%0d_%0d got err=%0d dv=%0d required err=1 dv=0", f_hi, f_lo, err_cnt_l - e0, dv_cnt_l - dv0);
        end
        word(data);
        n_vec++;
        if (dv_cnt_l != dv0 || d_l !== prev) begin
            n_bad++;
            $display("FAIL bad_width_one_word got dv=%0d D=%h required dv=0 D=%h", dv_cnt_l - dv0, d_l, prev);
        end
        push(data);
        word(data);
        n_vec++;
        if (dv_cnt_l != dv0 + 1 || exp_l.size() != 0 || d_l !== data || err_cnt_l != e0 + 1) begin
            n_bad++;
            $display("FAIL bad_width_recover got dv=%0d D=%h required dv=1 D=%h", dv_cnt_l - dv0, d_l, data);
        end
    endtask

    task automatic test_timeout();
        int dv0 = dv_cnt_l;
        hold(1'b0, VT_TO - 100);
        n_vec++;
        if ({vt_l, vt_m, d_l, d_m} !== {1'b1, 1'b1, 4'h5, 4'h5}) begin
            n_bad++;
            $display("FAIL timeout_early got %h required %h", {vt_l, vt_m, d_l, d_m}, {1'b1, 1'b1, 4'h5, 4'h5});
        end
        hold(1'b0, 200);
        n_vec++;
        if ({vt_l, vt_m, d_l, d_m} !== {1'b0, 1'b0, 4'h5, 4'h0} || dv_cnt_l != dv0 || dv_cnt_m != dv0) begin
            n_bad++;
            $display("FAIL timeout_drop got %h dv=%0d required %h dv=0", {vt_l, vt_m, d_l, d_m}, dv_cnt_l - dv0, {1'b0, 1'b0, 4'h5, 4'h0});
        end
    endtask

    task automatic test_reset_mid_word();
        int dv0;
        send_word(4'hA, 4, 12, 0, 0, 1'b0, 5);
        hold(1'b1, 2);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({d_l, dv_l, vt_l, err_l, d_m, dv_m, vt_m, err_m} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_mid_word got %h required 0", {d_l, dv_l, vt_l, err_l, d_m, dv_m, vt_m, err_m});
        end
        cod = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        dv0 = dv_cnt_l;
        send_sync();
        word(4'hA);
        n_vec++;
        if (dv_cnt_l != dv0 || {d_l, vt_l} !== 5'h0) begin
            n_bad++;
            $display("FAIL reset_one_word got dv=%0d D=%h vt=%b required dv=0 D=0 vt=0", dv_cnt_l - dv0, d_l, vt_l);
        end
        push(4'hA);
        word(4'hA);
        n_vec++;
        if (dv_cnt_l != dv0 + 1 || exp_m.size() != 0 || {d_l, vt_l, d_m, vt_m} !== {4'hA, 1'b1, 4'hA, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_recover got dv=%0d out=%h required dv=1 out=%h", dv_cnt_l - dv0, {d_l, vt_l, d_m, vt_m}, {4'hA, 1'b1, 4'hA, 1'b1});
        end
    endtask

    initial begin
        cod        = 1'b0;
        rst_n      = 1'b0;
        addr_float = 8'h44;
        addr_val   = 8'h0A;
        test_reset();
        send_sync();
        test_confirm();
        test_repeat();
        test_change();
        test_addr_mismatch();
        test_tolerance();
        test_bad_width(7, 12, 4'hA, 4'h5);
        test_bad_width(4, 16, 4'h5, 4'hA);
        test_timeout();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
